serial_sub_unit: RTL and testbench

//   Parametrised bit-serial subtractor: computes diff = a - b - bin over WIDTH bits,
//   one bit per clock, LSB first, through a single full-subtractor cell and a borrow

---
 rtl/lab_arith_pkg.sv | 16 +
 rtl/full_sub_cell.sv | 13 +
 rtl/serial_sub_unit.sv | 95 +++++++++
 tb/tb_serial_sub_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/lab_arith_pkg.sv
// Shared definitions for the lab arithmetic units: FSM state encoding and
// counter sizing helper.
package lab_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-counter width for a WIDTH-bit serial operation, never less than 1.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_sub_cell.sv
// Combinational 1-bit full subtractor: d = x - y - bin, with borrow-out.
module full_sub_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub_unit.sv
// Bit-serial subtractor: diff = a - b - bin over WIDTH bits, LSB first,
// through one full_sub_cell and a borrow flip-flop.
module serial_sub_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    import lab_arith_pkg::*;

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh, b_sh, res, res_nxt;
    logic             brw, a_msb, b_msb;
    logic             cell_d, cell_b;
    logic             load, last;

    full_sub_cell u_cell (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .bin  (brw),
        .d    (cell_d),
        .bout (cell_b)
    );

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign load = start && (state != RUN);
    assign last = (state == RUN) && (cnt == LAST);

    // Shift the new bit into the MSB; the width-1 form also covers WIDTH==1.
    assign res_nxt = WIDTH'({cell_d, res} >> 1);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            brw   <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                a_sh  <= a;
                b_sh  <= b;
                brw   <= bin;
                cnt   <= '0;
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
            end else if (state == RUN) begin
                a_sh <= a_sh >> 1;
                b_sh <= b_sh >> 1;
                brw  <= cell_b;
                res  <= res_nxt;
                cnt  <= cnt + CW'(1);
                // Published results only change here, so they hold across IDLE/RUN.
                if (last) begin
                    diff <= res_nxt;
                    bout <= cell_b;
                    ovf  <= (a_msb != b_msb) && (cell_d != a_msb);
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_sub_unit.sv
// Self-checking bench for serial_sub_unit: arithmetic reference model plus
// directed literal cases (WIDTH=8) and an exhaustive WIDTH=1 sweep.
module tb_serial_sub_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       bin = 1'b0;
    logic       busy, done, bout, ovf;
    logic [7:0] diff;

    logic       s1_start = 1'b0;
    logic [0:0] s1_a = '0, s1_b = '0;
    logic       s1_bin = 1'b0;
    logic       s1_busy, s1_done, s1_bout, s1_ovf;
    logic [0:0] s1_diff;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference model state (operation-level, not cycle-by-cycle RTL).
    int         cyc = 0;
    bit         m_active = 0, m_busy = 0, m_done = 0;
    int         m_done_at = 0;
    logic [7:0] m_diff = '0, p_diff = '0;
    bit         m_bout = 0, m_ovf = 0, p_bout = 0, p_ovf = 0;

    always #5 clk = ~clk;

    serial_sub_unit #(.WIDTH(8)) dut (
        .clk (clk), .rst_n (rst_n), .start (start), .a (a), .b (b), .bin (bin),
        .busy (busy), .done (done), .diff (diff), .bout (bout), .ovf (ovf)
    );

    serial_sub_unit #(.WIDTH(1)) dut1 (
        .clk (clk), .rst_n (rst_n), .start (s1_start), .a (s1_a), .b (s1_b), .bin (s1_bin),
        .busy (s1_busy), .done (s1_done), .diff (s1_diff), .bout (s1_bout), .ovf (s1_ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_loop();
        bit pre;
        int full, sa, sb, sf;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                m_active = 0; m_busy = 0; m_done = 0;
                m_diff = '0; m_bout = 0; m_ovf = 0;
            end else begin
                pre    = m_busy;
                m_done = 0;
                if (m_active && cyc == m_done_at) begin
                    m_done = 1; m_active = 0; m_busy = 0;
                    m_diff = p_diff; m_bout = p_bout; m_ovf = p_ovf;
                end
                if (start && !pre) begin
                    full   = int'(a) - int'(b) - int'(bin);
                    p_diff = full[7:0];
                    p_bout = (full < 0);
                    sa     = int'($signed(a));
                    sb     = int'($signed(b));
                    sf     = sa - sb - int'(bin);
                    p_ovf  = (sf < -128) || (sf > 127);
                    m_active = 1; m_busy = 1; m_done_at = cyc + 8;
                end
            end
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("busy", busy, m_busy);
                chk("done", done, m_done);
                chk("diff", diff, m_diff);
                chk("bout", bout, m_bout);
                chk("ovf",  ovf,  m_ovf);
            end
        end
    endtask

    // Caller is at a negedge; leaves the bench at the negedge of the done cycle.
    task automatic run_op(input string name, input logic [7:0] ia, input logic [7:0] ib,
                          input logic ibin, input logic [7:0] ed, input logic eb, input logic eo);
        int  k;
        bit  seen;
        start = 1'b1; a = ia; b = ib; bin = ibin;
        k = 0; seen = 0;
        while (k < 20 && !seen) begin
            @(negedge clk);
            start = 1'b0;
            k++;
            if (done) seen = 1;
        end
        chk({name, "_latency"}, k, 9);
        chk({name, "_diff"}, diff, ed);
        chk({name, "_bout"}, bout, eb);
        chk({name, "_ovf"},  ovf,  eo);
    endtask

    logic [1:0] tt [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

    initial begin
        int k, n_done, sf;
        bit seen;
        fork
            model_loop();
            compare_loop();
        join_none

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_diff", diff, 0);

        @(negedge clk);
        run_op("sub_5_3",   8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        @(negedge clk);
        run_op("sub_3_5",   8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
        @(negedge clk);
        run_op("sub_0_0_b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        @(negedge clk);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        // Back-to-back: start issued in the DONE cycle of the previous op.
        run_op("sub_7f_ff", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
        run_op("b2b",       8'h10, 8'h01, 1'b1, 8'h0E, 1'b0, 1'b0);

        // start pulsed while busy must be ignored.
        @(negedge clk);
        start = 1'b1; a = 8'h05; b = 8'h03; bin = 1'b0;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; a = 8'hAA; b = 8'h11; bin = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 4; seen = 0;
        while (k < 20 && !seen) begin
            @(negedge clk);
            k++;
            if (done) seen = 1;
        end
        chk("ignore_latency", k, 9);
        chk("ignore_diff", diff, 8'h02);
        chk("ignore_bout", bout, 0);

        // Reset mid-operation discards the result and suppresses done.
        @(negedge clk);
        start = 1'b1; a = 8'h44; b = 8'h22; bin = 1'b0;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midreset_busy", busy, 0);
        chk("midreset_done", done, 0);
        chk("midreset_diff", diff, 0);
        n_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("midreset_no_done", n_done, 0);

        // Random traffic, including starts while busy; checked by the model.
        n_done = 0;
        repeat (3000) begin
            @(negedge clk);
            if (done) n_done++;
            start = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0:       begin a = 8'h80; b = 8'h7F; end
                1:       begin a = 8'hFF; b = 8'h00; end
                2:       begin a = 8'h00; b = 8'hFF; end
                default: begin a = 8'($urandom); b = 8'($urandom); end
            endcase
            bin = 1'($urandom);
        end
        start = 1'b0;
        chk("random_ops_seen", (n_done >= 100), 1);

        // WIDTH=1 exhaustive truth table.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            s1_a[0] = i[2]; s1_b[0] = i[1]; s1_bin = i[0];
            s1_start = 1'b1;
            k = 0; seen = 0;
            while (k < 6 && !seen) begin
                @(negedge clk);
                s1_start = 1'b0;
                k++;
                if (k == 1) chk("w1_busy", s1_busy, 1);
                if (s1_done) seen = 1;
            end
            sf = -int'(s1_a[0]) + int'(s1_b[0]) - int'(s1_bin);
            chk("w1_latency", k, 2);
            chk("w1_truth", {s1_diff, s1_bout}, tt[i]);
            chk("w1_ovf", s1_ovf, ((sf < -1) || (sf > 0)));
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
